motion_seg_sequencer: RTL

MOTION_SEG_SEQUENCER -- requirements
Module: motion_seg_sequencer

---
 rtl/motion_pkg.sv | 36 +++
 rtl/seg_fifo.sv | 78 +++++++
 rtl/motion_seg_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/motion_pkg.sv
// Shared types for the motion segment sequencer: FSM state encoding,
// segment record layout and the default field width.
package motion_pkg;

    // Default width of the dt, steps, a and j fields.
    localparam int W_DEFAULT = 32;

    // Number of single-bit flags carried with every segment.
    localparam int SEG_FLAG_W = 3;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_RUN        = 2'd2,
        ST_ABORT_WAIT = 2'd3
    } state_t;

    // One queued segment at the default width. The queue word uses the same
    // field order (dt, steps, a, j, set_a, set_j, last) at any width W.
    typedef struct packed {
        logic [W_DEFAULT-1:0] dt;
        logic [W_DEFAULT-1:0] steps;
        logic [W_DEFAULT-1:0] a;
        logic [W_DEFAULT-1:0] j;
        logic                 set_a;
        logic                 set_j;
        logic                 last;
    } seg_t;

    // Width of one packed queue word for field width w.
    function automatic int seg_word_width(input int w);
        return 4 * w + SEG_FLAG_W;
    endfunction

endpackage

// File: rtl/seg_fifo.sv
// Segment queue: DEPTH-entry FIFO with occupancy count and synchronous flush.
// The head entry is read combinationally so the sequencer can capture it on
// the same edge it pops, keeping load one clock after start/seg_done.
module seg_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DW-1:0]             wr_data,
    output logic [DW-1:0]             rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer and count update; flush empties the queue and wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers; reset discards any queued contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/motion_seg_sequencer.sv
// Motion segment sequencer: queues motion segments and hands them one at a
// time to the step/profile generators with a one-cycle load strobe, advancing
// on each seg_done until the last segment, an underrun or an abort.
module motion_seg_sequencer
    import motion_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_dt,
    input  logic [W-1:0]           wr_steps,
    input  logic [W-1:0]           wr_a,
    input  logic [W-1:0]           wr_j,
    input  logic                   wr_set_a,
    input  logic                   wr_set_j,
    input  logic                   wr_last,
    input  logic                   start,
    input  logic                   seg_done,
    input  logic                   abort,
    output logic                   load,
    output logic [W-1:0]           dt_val,
    output logic [W-1:0]           steps_val,
    output logic [W-1:0]           a_val,
    output logic [W-1:0]           j_val,
    output logic                   set_a,
    output logic                   set_j,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   underrun
);

    localparam int DW = seg_word_width(W);

    state_t state_q, state_d;

    // Queue interface
    logic [DW-1:0] wr_word;
    logic [DW-1:0] head_word;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          flush;

    // Head entry fields
    logic [W-1:0]  head_dt;
    logic [W-1:0]  head_steps;
    logic [W-1:0]  head_a;
    logic [W-1:0]  head_j;
    logic          head_set_a;
    logic          head_set_j;
    logic          head_last;

    // Output and bookkeeping registers
    logic          load_q, load_d;
    logic          set_a_q, set_a_d;
    logic          set_j_q, set_j_d;
    logic [W-1:0]  dt_q, dt_d;
    logic [W-1:0]  steps_q, steps_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  j_q, j_d;
    logic          last_q, last_d;
    logic          underrun_q, underrun_d;

    assign wr_word    = {wr_dt, wr_steps, wr_a, wr_j, wr_set_a, wr_set_j, wr_last};
    assign head_dt    = head_word[DW-1     -: W];
    assign head_steps = head_word[DW-1-W   -: W];
    assign head_a     = head_word[DW-1-2*W -: W];
    assign head_j     = head_word[DW-1-3*W -: W];
    assign head_set_a = head_word[2];
    assign head_set_j = head_word[1];
    assign head_last  = head_word[0];

    seg_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_seg_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_word),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; abort outranks start and seg_done.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            if (state_q == ST_LOAD || state_q == ST_RUN) begin
                state_d = ST_ABORT_WAIT;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !fifo_empty) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (seg_done) begin
                        state_d = (!last_q && !fifo_empty) ? ST_LOAD : ST_IDLE;
                    end
                end
                ST_ABORT_WAIT: begin
                    if (seg_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs: the head is popped and latched on the edge that enters
    // LOAD, so load is high for exactly the LOAD cycle. A write at full is
    // still taken when the same edge pops, since a slot frees up.
    always_comb begin
        flush      = abort;
        pop        = (state_d == ST_LOAD);
        push       = wr_en && !abort && (state_q != ST_ABORT_WAIT) && (!fifo_full || pop);

        load_d     = pop;
        set_a_d    = pop && head_set_a;
        set_j_d    = pop && head_set_j;
        dt_d       = pop ? head_dt    : dt_q;
        steps_d    = pop ? head_steps : steps_q;
        a_d        = pop ? head_a     : a_q;
        j_d        = pop ? head_j     : j_q;
        last_d     = pop ? head_last  : last_q;

        underrun_d = underrun_q;
        if (!abort && state_q == ST_IDLE && start && !fifo_empty) begin
            underrun_d = 1'b0;
        end else if (!abort && state_q == ST_RUN && seg_done && !last_q && fifo_empty) begin
            underrun_d = 1'b1;
        end
    end

    // Registered strobe, segment fields and sticky underrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_q     <= 1'b0;
            set_a_q    <= 1'b0;
            set_j_q    <= 1'b0;
            dt_q       <= '0;
            steps_q    <= '0;
            a_q        <= '0;
            j_q        <= '0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            load_q     <= load_d;
            set_a_q    <= set_a_d;
            set_j_q    <= set_j_d;
            dt_q       <= dt_d;
            steps_q    <= steps_d;
            a_q        <= a_d;
            j_q        <= j_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
        end
    end

    assign load      = load_q;
    assign set_a     = set_a_q;
    assign set_j     = set_j_q;
    assign dt_val    = dt_q;
    assign steps_val = steps_q;
    assign a_val     = a_q;
    assign j_val     = j_q;
    assign full      = fifo_full;
    assign empty     = fifo_empty;
    assign busy      = (state_q != ST_IDLE);
    assign underrun  = underrun_q;

endmodule
